// File: rtl/gb_cpu_common_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : gb_cpu_common_pkg
//  Description : Shared CPU types and constants: interrupt indices, vector
//                base, IE/IF bus addresses and dispatch sequencer states.
//  Revision    : 1.0 - initial release
// ============================================================================
package gb_cpu_common_pkg;

    localparam int         IRQ_COUNT    = 5;
    localparam logic [7:0] IRQ_VEC_BASE = 8'h40;
    localparam logic [15:0] ADDR_IE     = 16'hFFFF;
    localparam logic [15:0] ADDR_IF     = 16'hFF0F;

    // Bit position of each request in IE/IF; lower index wins arbitration.
    typedef enum logic [2:0] {
        VBLANK = 3'd0,
        STAT   = 3'd1,
        TIMER  = 3'd2,
        SERIAL = 3'd3,
        JOYPAD = 3'd4
    } irq_idx_t;

    // Encoding equals the dispatch M-cycle number, so the state doubles as
    // the externally visible cycle counter.
    typedef enum logic [2:0] {
        IDLE = 3'd0,
        D1   = 3'd1,
        D2   = 3'd2,
        D3   = 3'd3,
        D4   = 3'd4,
        D5   = 3'd5
    } irq_dispatch_state_t;

    // Vector for a request index: 40, 48, 50, 58, 60.
    function automatic logic [7:0] irq_vector(input logic [2:0] idx);
        return IRQ_VEC_BASE + {2'b00, idx, 3'b000};
    endfunction

endpackage
`default_nettype wire

// File: rtl/gb_cpu_irq_prio_enc.sv
`default_nettype none
// ============================================================================
//  Module      : gb_cpu_irq_prio_enc
//  Description : Fixed-priority encoder over the pending interrupt bits.
//                Bit 0 (VBlank) has highest priority.
//  Revision    : 1.0 - initial release
// ============================================================================
module gb_cpu_irq_prio_enc
    import gb_cpu_common_pkg::*;
(
    input  logic [4:0] i_pending,
    output logic       o_valid,
    output logic [2:0] o_index,
    output logic [7:0] o_vector,
    output logic [4:0] o_ack_mask
);

    // Scan from lowest priority upward so the lowest set bit wins.
    always_comb begin
        o_valid    = |i_pending;
        o_index    = 3'd0;
        for (int i = IRQ_COUNT - 1; i >= 0; i--) begin
            if (i_pending[i]) begin
                o_index = 3'(i);
            end
        end
        o_ack_mask = o_valid ? (5'b00001 << o_index) : 5'b00000;
        o_vector   = o_valid ? irq_vector(o_index) : 8'h00;
    end

endmodule
`default_nettype wire

// File: rtl/gb_cpu_interrupt_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : gb_cpu_interrupt_ctrl
//  Description : IE/IF registers, IME and the five M-cycle interrupt
//                dispatch sequencer feeding the CPU control unit.
//  Revision    : 1.0 - initial release
// ============================================================================
module gb_cpu_interrupt_ctrl
    import gb_cpu_common_pkg::*;
#(
    parameter logic [4:0] IF_RESET = 5'h01,
    parameter logic [7:0] IE_RESET = 8'h00
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  irq_req,
    input  logic [15:0] bus_addr,
    input  logic [7:0]  bus_wdata,
    input  logic        bus_wren,
    output logic [7:0]  bus_rdata,
    output logic        bus_hit,
    input  logic        cmd_ei,
    input  logic        cmd_di,
    input  logic        cmd_reti,
    input  logic        last_m_cycle,
    output logic        interrupt_queued,
    output logic        interrupt_queued_no_IME,
    output logic        enable_interrupts_delayed,
    output logic        dispatch_active,
    output logic [2:0]  dispatch_cycle,
    output logic        write_interrupt_vector,
    output logic [7:0]  interrupt_vector
);

    logic [4:0]          r_if;
    logic [7:0]          r_ie;
    logic                r_ime;
    logic                r_ei_pending;
    irq_dispatch_state_t r_state;
    logic                r_active;
    logic                r_write_vec;
    logic [7:0]          r_vector;

    logic [4:0]          w_pending;
    logic                w_ie_sel;
    logic                w_if_sel;
    logic                w_enc_valid;
    logic [2:0]          w_enc_index;
    logic [7:0]          w_enc_vector;
    logic [4:0]          w_enc_ack;
    logic [4:0]          w_ack;
    logic [4:0]          w_if_next;
    logic                w_start;

    assign w_pending = r_ie[4:0] & r_if;
    assign w_ie_sel  = (bus_addr == ADDR_IE);
    assign w_if_sel  = (bus_addr == ADDR_IF);

    gb_cpu_irq_prio_enc u_prio_enc (
        .i_pending  (w_pending),
        .o_valid    (w_enc_valid),
        .o_index    (w_enc_index),
        .o_vector   (w_enc_vector),
        .o_ack_mask (w_enc_ack)
    );

    // Combinational register readback; unused IF bits read as 1.
    always_comb begin
        bus_hit   = w_ie_sel | w_if_sel;
        bus_rdata = 8'h00;
        if (w_if_sel) begin
            bus_rdata = {3'b111, r_if};
        end else if (w_ie_sel) begin
            bus_rdata = r_ie;
        end
    end

    assign interrupt_queued          = r_ime & (|w_pending) & ~r_active;
    assign interrupt_queued_no_IME   = ~r_ime & (|w_pending);
    assign enable_interrupts_delayed = r_ei_pending;
    assign dispatch_active           = r_active;
    assign dispatch_cycle            = r_state;
    assign write_interrupt_vector    = r_write_vec;
    assign interrupt_vector          = r_vector;

    assign w_start = (r_state == IDLE) & interrupt_queued & last_m_cycle;
    assign w_ack   = (r_state == D4) ? w_enc_ack : 5'b00000;

    // IF next value: bus write, then acknowledge, then new requests on top.
    always_comb begin
        w_if_next = r_if;
        if (bus_wren && w_if_sel) begin
            w_if_next = bus_wdata[4:0];
        end
        w_if_next = w_if_next & ~w_ack;
        w_if_next = w_if_next | irq_req;
    end

    // IE/IF storage.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_if <= IF_RESET;
            r_ie <= IE_RESET;
        end else begin
            r_if <= w_if_next;
            if (bus_wren && w_ie_sel) begin
                r_ie <= bus_wdata;
            end
        end
    end

    // IME and the one-instruction EI delay; later statements take priority.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_ime        <= 1'b0;
            r_ei_pending <= 1'b0;
        end else begin
            if (cmd_ei && !r_ime) begin
                r_ei_pending <= 1'b1;
            end
            if (r_ei_pending && last_m_cycle) begin
                r_ime        <= 1'b1;
                r_ei_pending <= 1'b0;
            end
            if (cmd_reti) begin
                r_ime <= 1'b1;
            end
            if (r_state == D1) begin
                r_ime        <= 1'b0;
                r_ei_pending <= 1'b0;
            end
            if (cmd_di) begin
                r_ime        <= 1'b0;
                r_ei_pending <= 1'b0;
            end
        end
    end

    // Dispatch sequencer with registered strobes and latched vector.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= IDLE;
            r_active    <= 1'b0;
            r_write_vec <= 1'b0;
            r_vector    <= 8'h00;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_start) begin
                        r_state  <= D1;
                        r_active <= 1'b1;
                    end
                end
                D1: r_state <= D2;
                D2: r_state <= D3;
                D3: r_state <= D4;
                D4: begin
                    r_state     <= D5;
                    r_vector    <= w_enc_valid ? w_enc_vector : 8'h00;
                    r_write_vec <= 1'b1;
                end
                D5: begin
                    r_state     <= IDLE;
                    r_write_vec <= 1'b0;
                    r_active    <= 1'b0;
                end
                default: begin
                    r_state     <= IDLE;
                    r_write_vec <= 1'b0;
                    r_active    <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_gb_cpu_interrupt_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_gb_cpu_interrupt_ctrl
//  Description : Directed scoreboard bench for gb_cpu_interrupt_ctrl.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_gb_cpu_interrupt_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic [4:0]  irq_req;
    logic [15:0] bus_addr;
    logic [7:0]  bus_wdata;
    logic        bus_wren;
    logic [7:0]  bus_rdata;
    logic        bus_hit;
    logic        cmd_ei, cmd_di, cmd_reti, last_m_cycle;
    logic        interrupt_queued, interrupt_queued_no_IME;
    logic        enable_interrupts_delayed, dispatch_active;
    logic [2:0]  dispatch_cycle;
    logic        write_interrupt_vector;
    logic [7:0]  interrupt_vector;

    int          checks = 0;
    int          errors = 0;
    logic        rd_req = 1'b0;
    logic [7:0]  exp_rd_q[$];
    logic [7:0]  exp_vec_q[$];

    gb_cpu_interrupt_ctrl dut (
        .clk                       (clk),
        .reset                     (reset),
        .irq_req                   (irq_req),
        .bus_addr                  (bus_addr),
        .bus_wdata                 (bus_wdata),
        .bus_wren                  (bus_wren),
        .bus_rdata                 (bus_rdata),
        .bus_hit                   (bus_hit),
        .cmd_ei                    (cmd_ei),
        .cmd_di                    (cmd_di),
        .cmd_reti                  (cmd_reti),
        .last_m_cycle              (last_m_cycle),
        .interrupt_queued          (interrupt_queued),
        .interrupt_queued_no_IME   (interrupt_queued_no_IME),
        .enable_interrupts_delayed (enable_interrupts_delayed),
        .dispatch_active           (dispatch_active),
        .dispatch_cycle            (dispatch_cycle),
        .write_interrupt_vector    (write_interrupt_vector),
        .interrupt_vector          (interrupt_vector)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %02h expected %02h", name, act, exp);
        end
    endtask

    // Monitor: pops expected data whenever a read or a vector strobe is presented.
    always @(negedge clk) begin
        if (rd_req) begin
            if (exp_rd_q.size() == 0) begin
                chk("rd_unexpected", 8'h01, 8'h00);
            end else begin
                chk("bus_rdata", bus_rdata, exp_rd_q.pop_front());
                chk("bus_hit", {7'd0, bus_hit}, 8'h01);
            end
        end
        if (write_interrupt_vector === 1'b1) begin
            if (exp_vec_q.size() == 0) begin
                chk("vec_unexpected", interrupt_vector, 8'hFF);
            end else begin
                chk("interrupt_vector", interrupt_vector, exp_vec_q.pop_front());
                chk("d5_cycle", {5'd0, dispatch_cycle}, 8'h05);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [15:0] a, input logic [7:0] d);
        bus_addr  = a;
        bus_wdata = d;
        bus_wren  = 1'b1;
        tick();
        bus_wren  = 1'b0;
    endtask

    task automatic rd(input logic [15:0] a, input logic [7:0] e);
        tick();
        bus_addr = a;
        exp_rd_q.push_back(e);
        rd_req = 1'b1;
        @(negedge clk);
        #1;
        rd_req = 1'b0;
    endtask

    task automatic pulse_reti();
        cmd_reti = 1'b1;
        tick();
        cmd_reti = 1'b0;
    endtask

    task automatic pulse_irq(input logic [4:0] r);
        irq_req = r;
        tick();
        irq_req = 5'd0;
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b1; irq_req = 5'd0; bus_addr = 16'h0000; bus_wdata = 8'h00;
        bus_wren = 1'b0; cmd_ei = 1'b0; cmd_di = 1'b0; cmd_reti = 1'b0;
        last_m_cycle = 1'b0;
        tick(); tick();
        reset = 1'b0;

        // Reset state
        chk("rst_cycle", {5'd0, dispatch_cycle}, 8'h00);
        chk("rst_strobes", {3'd0, interrupt_queued, interrupt_queued_no_IME,
            enable_interrupts_delayed, dispatch_active, write_interrupt_vector}, 8'h00);
        chk("rst_vector", interrupt_vector, 8'h00);
        rd(16'hFF0F, 8'hE1);
        rd(16'hFFFF, 8'h00);
        tick();
        bus_addr = 16'h1234;
        #1;
        chk("miss_rdata", bus_rdata, 8'h00);
        chk("miss_hit", {7'd0, bus_hit}, 8'h00);

        // Timer dispatch with IME=1
        pulse_reti();
        wr(16'hFF0F, 8'h00);
        wr(16'hFFFF, 8'h04);
        pulse_irq(5'h04);
        chk("t2_queued", {7'd0, interrupt_queued}, 8'h01);
        exp_vec_q.push_back(8'h50);
        last_m_cycle = 1'b1;
        tick();
        last_m_cycle = 1'b0;
        chk("t2_d1", {5'd0, dispatch_cycle}, 8'h01);
        chk("t2_active", {7'd0, dispatch_active}, 8'h01);
        chk("t2_q_forced0", {7'd0, interrupt_queued}, 8'h00);
        for (int c = 2; c <= 5; c++) begin
            tick();
            chk("t2_cycle", {5'd0, dispatch_cycle}, 8'(c));
        end
        chk("t2_wv", {7'd0, write_interrupt_vector}, 8'h01);
        tick();
        chk("t2_idle", {5'd0, dispatch_cycle}, 8'h00);
        chk("t2_wv_off", {7'd0, write_interrupt_vector}, 8'h00);
        rd(16'hFF0F, 8'hE0);
        tick();
        pulse_irq(5'h04);
        chk("t2_ime_off", {6'd0, interrupt_queued_no_IME, interrupt_queued}, 8'h02);

        // EI delay across a one-cycle instruction
        cmd_ei = 1'b1;
        last_m_cycle = 1'b1;
        tick();
        cmd_ei = 1'b0;
        chk("ei_delayed", {7'd0, enable_interrupts_delayed}, 8'h01);
        chk("ei_not_yet", {7'd0, interrupt_queued}, 8'h00);
        tick();
        last_m_cycle = 1'b0;
        chk("ei_ime_set", {7'd0, interrupt_queued}, 8'h01);
        chk("ei_delay_clr", {7'd0, enable_interrupts_delayed}, 8'h00);
        cmd_di = 1'b1;
        tick();
        cmd_di = 1'b0;
        chk("di_clears", {6'd0, interrupt_queued_no_IME, interrupt_queued}, 8'h02);
        cmd_ei = 1'b1; cmd_di = 1'b1;
        tick();
        cmd_ei = 1'b0; cmd_di = 1'b0;
        chk("di_over_ei", {7'd0, enable_interrupts_delayed}, 8'h00);

        // Cancel: IE cleared during D3
        wr(16'hFFFF, 8'h01);
        wr(16'hFF0F, 8'h01);
        pulse_reti();
        exp_vec_q.push_back(8'h00);
        last_m_cycle = 1'b1;
        tick();
        last_m_cycle = 1'b0;
        tick(); tick();
        chk("cx_d3", {5'd0, dispatch_cycle}, 8'h03);
        wr(16'hFFFF, 8'h00);
        tick();
        tick();
        chk("cx_idle", {5'd0, dispatch_cycle}, 8'h00);
        rd(16'hFF0F, 8'hE1);
        rd(16'hFFFF, 8'h00);

        // Queued without IME, then RETI releases serial dispatch
        tick();
        wr(16'hFF0F, 8'h00);
        wr(16'hFFFF, 8'h1F);
        pulse_irq(5'h18);
        chk("noime_q", {6'd0, interrupt_queued_no_IME, interrupt_queued}, 8'h02);
        pulse_reti();
        chk("reti_q", {6'd0, interrupt_queued_no_IME, interrupt_queued}, 8'h01);
        exp_vec_q.push_back(8'h58);
        last_m_cycle = 1'b1;
        tick();
        last_m_cycle = 1'b0;
        for (int k = 0; k < 5; k++) tick();
        rd(16'hFF0F, 8'hF0);

        // New request beats a same-cycle IF write
        tick();
        irq_req = 5'h02;
        wr(16'hFF0F, 8'h00);
        irq_req = 5'h00;
        rd(16'hFF0F, 8'hE2);

        // Reset during D3 aborts without acknowledging
        tick();
        pulse_reti();
        last_m_cycle = 1'b1;
        tick();
        last_m_cycle = 1'b0;
        tick(); tick();
        chk("rs_d3", {5'd0, dispatch_cycle}, 8'h03);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("rs_idle", {5'd0, dispatch_cycle}, 8'h00);
        chk("rs_strobes", {6'd0, dispatch_active, write_interrupt_vector}, 8'h00);
        rd(16'hFF0F, 8'hE1);
        rd(16'hFFFF, 8'h00);
        for (int k = 0; k < 4; k++) tick();

        chk("vec_q_empty", 8'(exp_vec_q.size()), 8'h00);
        chk("rd_q_empty", 8'(exp_rd_q.size()), 8'h00);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
